// File: rtl/neopixel_stream_decoder_pkg.sv
// Shared timing constants, pixel type and decoder state encoding for the
// NeoPixel stream decoder.
package neopixel_pkg;

  localparam int unsigned LATCH_CYCLES = 2500;
  localparam int unsigned T_MIN        = 8;
  localparam int unsigned T_SPLIT      = 27;
  localparam int unsigned T_MAX        = 50;

  localparam int unsigned WIDTH_W = 6;
  localparam int unsigned LOW_W   = 12;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_DRAIN = 2'd3
  } dec_state_t;

  function automatic logic [LOW_W-1:0] low_sat_inc(input logic [LOW_W-1:0] v);
    logic [LOW_W-1:0] r;
    if (v == {LOW_W{1'b1}}) r = v;
    else                    r = v + LOW_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/neopixel_stream_decoder_if.sv
// Decoded pixel / frame status bundle; master drives it, slave consumes it.
interface neopixel_stream_decoder_if;
  logic       pixel_valid;
  logic [2:0] pixel_index;
  logic [7:0] green;
  logic [7:0] red;
  logic [7:0] blue;
  logic       frame_done;
  logic       frame_error;
  logic       busy;

  modport master (
    output pixel_valid, pixel_index, green, red, blue,
    output frame_done, frame_error, busy
  );

  modport slave (
    input pixel_valid, pixel_index, green, red, blue,
    input frame_done, frame_error, busy
  );
endinterface

// File: rtl/neopixel_stream_decoder_pulse_width_meter.sv
// Synchronizes the raw serial line, detects its edges and measures how many
// cycles the current high pulse has lasted (saturating).
module pulse_width_meter
  import neopixel_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               neo_data,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic [WIDTH_W-1:0] width
);

  logic               sync1_q;
  logic               sync2_q;
  logic               prev_q;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] width_d;

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign width = width_q;

  // On a falling edge width holds the number of high cycles just seen.
  always_comb begin
    width_d = width_q;
    if (rise) begin
      width_d = WIDTH_W'(1);
    end else if (sync2_q && (width_q != {WIDTH_W{1'b1}})) begin
      width_d = width_q + WIDTH_W'(1);
    end else begin
      width_d = width_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      width_q <= {WIDTH_W{1'b0}};
    end else begin
      sync1_q <= neo_data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      width_q <= width_d;
    end
  end

endmodule

// File: rtl/neopixel_stream_decoder.sv
// NeoPixel (WS2812-style) serial decoder: classifies high-pulse widths into
// bits, assembles 24-bit GRB pixels and reports frame completion / errors.
module neopixel_stream_decoder #(
  parameter int unsigned NUM_PIXELS   = 5,
  parameter int unsigned LATCH_CYCLES = neopixel_pkg::LATCH_CYCLES,
  parameter int unsigned T_MIN        = neopixel_pkg::T_MIN,
  parameter int unsigned T_SPLIT      = neopixel_pkg::T_SPLIT,
  parameter int unsigned T_MAX        = neopixel_pkg::T_MAX
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      neo_data,
  neopixel_stream_decoder_if.master px
);
  import neopixel_pkg::*;

  dec_state_t         state_q, state_d;
  logic [LOW_W-1:0]   low_q, low_d;
  logic [23:0]        shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         pix_cnt_q, pix_cnt_d;
  logic               err_q, err_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [2:0]         pixel_index_q, pixel_index_d;
  grb_t               pixel_q, pixel_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_error_q, frame_error_d;
  logic               busy_q, busy_d;

  logic               level_s, rise_s, fall_s;
  logic [WIDTH_W-1:0] width_s;
  logic               bit_ok_s, bit_val_s, frame_end_s;
  logic [23:0]        word_s;

  pulse_width_meter u_meter (
    .clock    (clock),
    .reset    (reset),
    .neo_data (neo_data),
    .level    (level_s),
    .rise     (rise_s),
    .fall     (fall_s),
    .width    (width_s)
  );

  // Next-state, bit assembly and frame bookkeeping.
  always_comb begin
    state_d       = state_q;
    low_d         = low_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    err_d         = err_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    pixel_d       = pixel_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    bit_ok_s      = 1'b0;
    bit_val_s     = 1'b0;
    frame_end_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise_s) state_d = S_HIGH;
        else        state_d = S_IDLE;
      end
      S_HIGH: begin
        // Over-long pulses abandon the frame until the line has been quiet.
        if (width_s > WIDTH_W'(T_MAX)) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
          low_d   = {LOW_W{1'b0}};
        end else if (fall_s) begin
          state_d = S_LOW;
          low_d   = LOW_W'(1);
          if (width_s < WIDTH_W'(T_MIN)) begin
            err_d = 1'b1;
          end else begin
            bit_ok_s  = 1'b1;
            bit_val_s = (width_s >= WIDTH_W'(T_SPLIT));
          end
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (rise_s)                              state_d = S_HIGH;
        else if (low_q >= LOW_W'(LATCH_CYCLES))  frame_end_s = 1'b1;
        else                                     low_d = low_sat_inc(low_q);
      end
      S_DRAIN: begin
        if (level_s)                             low_d = {LOW_W{1'b0}};
        else if (low_q >= LOW_W'(LATCH_CYCLES))  frame_end_s = 1'b1;
        else                                     low_d = low_sat_inc(low_q);
      end
      default: state_d = S_IDLE;
    endcase

    word_s = {shift_q[22:0], bit_val_s};
    if (bit_ok_s) begin
      if (bit_cnt_q == 5'd23) begin
        bit_cnt_d = 5'd0;
        shift_d   = 24'd0;
        if (pix_cnt_q < 3'(NUM_PIXELS)) begin
          pixel_valid_d = 1'b1;
          pixel_index_d = pix_cnt_q;
          pixel_d       = grb_t'(word_s);
          pix_cnt_d     = pix_cnt_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        shift_d   = word_s;
      end
    end else begin
      shift_d = shift_d;
    end

    if (frame_end_s) begin
      frame_done_d  = 1'b1;
      frame_error_d = err_q | (bit_cnt_q != 5'd0) | (pix_cnt_q != 3'(NUM_PIXELS));
      state_d       = S_IDLE;
      err_d         = 1'b0;
      bit_cnt_d     = 5'd0;
      pix_cnt_d     = 3'd0;
      shift_d       = 24'd0;
      low_d         = {LOW_W{1'b0}};
    end else begin
      frame_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      low_q         <= {LOW_W{1'b0}};
      shift_q       <= 24'd0;
      bit_cnt_q     <= 5'd0;
      pix_cnt_q     <= 3'd0;
      err_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= 3'd0;
      pixel_q       <= grb_t'(24'd0);
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      err_q         <= err_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      pixel_q       <= pixel_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign px.pixel_valid = pixel_valid_q;
  assign px.pixel_index = pixel_index_q;
  assign px.green       = pixel_q.g;
  assign px.red         = pixel_q.r;
  assign px.blue        = pixel_q.b;
  assign px.frame_done  = frame_done_q;
  assign px.frame_error = frame_error_q;
  assign px.busy        = busy_q;

endmodule

// File: tb/tb_neopixel_stream_decoder.sv
// Self-checking bench: builds frames as lists of (high, low) pulse widths and
// predicts the decoded pixels and frame status from the pulse rules.
module tb_neopixel_stream_decoder;

  localparam int NP      = 5;
  localparam int T_MIN   = 8;
  localparam int T_SPLIT = 27;
  localparam int T_MAX   = 50;
  localparam int LATCH   = 2500;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic neo_data = 1'b0;

  neopixel_stream_decoder_if px();

  neopixel_stream_decoder #(
    .NUM_PIXELS   (NP),
    .LATCH_CYCLES (LATCH),
    .T_MIN        (T_MIN),
    .T_SPLIT      (T_SPLIT),
    .T_MAX        (T_MAX)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .neo_data (neo_data),
    .px       (px)
  );

  always #10 clock = ~clock;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          hi_q[$];
  int          lo_q[$];
  logic [26:0] cap_pix[$];
  logic        cap_err[$];
  logic [26:0] exp_pix[$];
  logic        exp_err;
  logic        busy_mid;

  // Record every strobe as {index, G, R, B} and every frame status.
  always @(negedge clock) begin
    if (px.pixel_valid) cap_pix.push_back({px.pixel_index, px.green, px.red, px.blue});
    if (px.frame_done)  cap_err.push_back(px.frame_error);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic add_raw(input int h, input int l);
    hi_q.push_back(h);
    lo_q.push_back(l);
  endtask

  task automatic add_bit(input logic b);
    if (b) add_raw($urandom_range(T_MAX, T_SPLIT), $urandom_range(12, 6));
    else   add_raw($urandom_range(T_SPLIT - 1, T_MIN), $urandom_range(12, 6));
  endtask

  task automatic add_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) add_bit(v[i]);
  endtask

  task automatic add_fixed_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) begin
      if (v[i]) add_raw(35, 27);
      else      add_raw(18, 44);
    end
  endtask

  // Expected decode of the queued pulse list.
  task automatic model();
    int          nbits = 0;
    int          cnt   = 0;
    logic        err   = 1'b0;
    logic        drain = 1'b0;
    logic [23:0] acc   = 24'd0;
    exp_pix.delete();
    foreach (hi_q[i]) begin
      if (!drain) begin
        if (hi_q[i] > T_MAX) begin
          drain = 1'b1;
          err   = 1'b1;
        end else if (hi_q[i] < T_MIN) begin
          err = 1'b1;
        end else begin
          acc = {acc[22:0], (hi_q[i] >= T_SPLIT)};
          nbits++;
          if (nbits == 24) begin
            if (cnt < NP) exp_pix.push_back({cnt[2:0], acc});
            else          err = 1'b1;
            cnt++;
            nbits = 0;
          end
        end
      end
    end
    exp_err = err || (nbits != 0) || (cnt != NP);
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      neo_data = 1'b1;
      step(hi_q[i]);
      if (i == 0) busy_mid = px.busy;
      neo_data = 1'b0;
      step(lo_q[i]);
    end
  endtask

  task automatic run_frame(input string tag);
    int n;
    lo_q[lo_q.size() - 1] = LATCH + 100;
    model();
    cap_pix.delete();
    cap_err.delete();
    drive(hi_q.size());
    step(10);
    check({tag, " busy_mid"}, busy_mid, 1);
    check({tag, " frame_done_count"}, cap_err.size(), 1);
    if (cap_err.size() > 0) check({tag, " frame_error"}, cap_err[0], exp_err);
    check({tag, " pixel_count"}, cap_pix.size(), exp_pix.size());
    n = (cap_pix.size() < exp_pix.size()) ? cap_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) check($sformatf("%s pixel%0d", tag, i), cap_pix[i], exp_pix[i]);
    check({tag, " busy_idle"}, px.busy, 0);
    hi_q.delete();
    lo_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " pixel_valid"}, px.pixel_valid, 0);
    check({tag, " frame_done"},  px.frame_done, 0);
    check({tag, " frame_error"}, px.frame_error, 0);
    check({tag, " busy"},        px.busy, 0);
    check({tag, " index"},       px.pixel_index, 0);
    check({tag, " grb"},         {px.green, px.red, px.blue}, 0);
  endtask

  initial begin
    int w_list[6];
    w_list = '{7, 8, 26, 27, 50, 51};

    reset    = 1'b1;
    neo_data = 1'b0;
    step(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    step(5);

    for (int i = 0; i < NP; i++) add_fixed_pixel(24'hFF00A5);
    run_frame("fixed");

    for (int i = 0; i < NP; i++) add_pixel(24'($urandom) ^ 24'(i));
    run_frame("random");

    for (int i = 0; i < 3; i++) add_pixel(24'($urandom));
    for (int i = 0; i < 10; i++) add_bit(1'($urandom));
    run_frame("partial");

    for (int i = 0; i < 2; i++) add_pixel(24'($urandom));
    add_raw(60, 20);
    add_pixel(24'($urandom));
    run_frame("drain");

    foreach (w_list[k]) begin
      add_raw(w_list[k], 10);
      for (int i = 0; i < 23; i++) add_bit(1'($urandom));
      run_frame($sformatf("width%0d", w_list[k]));
    end

    for (int i = 0; i < NP + 1; i++) add_pixel(24'($urandom));
    run_frame("overflow");

    for (int i = 0; i < NP; i++) add_pixel(24'($urandom));
    drive(24 * 2 + 10);
    reset = 1'b1;
    step(2);
    check_outputs_zero("midreset");
    reset = 1'b0;
    cap_pix.delete();
    cap_err.delete();
    step(LATCH + 100);
    check("midreset no_frame_done", cap_err.size(), 0);
    check("midreset no_pixel", cap_pix.size(), 0);
    hi_q.delete();
    lo_q.delete();
    for (int i = 0; i < NP; i++) add_pixel(24'($urandom));
    run_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_stream_decoder.md
NEOPIXEL_STREAM_DECODER -- requirements
Module: neopixel_stream_decoder

Interface
REQ-001 Parameters (name, default, meaning): NUM_PIXELS, 5, pixels per frame; LATCH_CYCLES, 2500, low-time ending a frame (50 us at 50 MHz); T_MIN, 8, shortest legal high pulse; T_SPLIT, 27, high width at or above which a bit is 1; T_MAX, 50, longest legal high pulse.
REQ-002 Ports: clock  in  1  50 MHz system clock.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 neo_data  in  1  asynchronous serial line, the output of the NeoPixel strand transmitter.
REQ-005 pixel_valid  out  1  one-cycle strobe: a 24-bit pixel command was decoded.
REQ-006 pixel_index  out  3  pixel position in frame, 0 first; valid with pixel_valid.
REQ-007 green, red, blue  out  8 each  decoded levels; valid with pixel_valid.
REQ-008 frame_done  out  1  one-cycle strobe at the end of every frame.
REQ-009 frame_error  out  1  valid with frame_done; 1 = frame malformed.
REQ-010 busy  out  1  high from first rising edge of a frame until frame_done.

Function
REQ-011 neo_data SHALL pass a 2-flop synchronizer plus one edge-detect register; all timing counts use the synchronized signal.
REQ-012 FSM states: IDLE, HIGH, LOW, DRAIN.
REQ-013 IDLE: on synchronized rising edge -> HIGH, width counter cleared to 1, busy = 1.
REQ-014 HIGH: counter increments each cycle; falling edge -> LOW; counter reaching T_MAX+1 while high -> DRAIN, error latched.
REQ-015 At falling edge, width w SHALL classify: w < T_MIN -> error latched, no bit; T_MIN <= w < T_SPLIT -> bit 0; T_SPLIT <= w <= T_MAX -> bit 1.
REQ-016 Bits SHALL shift into a 24-bit register MSB first, order G[7:0], R[7:0], B[7:0].
REQ-017 24th accepted bit: pixel_valid high the next cycle for exactly one cycle, green/red/blue/pixel_index held until the next strobe; bit counter clears; pixel counter increments.
REQ-018 LOW: counter counts low cycles; rising edge -> HIGH with counter = 1; low count reaching LATCH_CYCLES -> frame end.
REQ-019 Frame end: frame_done pulses one cycle; frame_error = 1 if any error latched, bit counter nonzero (partial word, discarded), or pixel count != NUM_PIXELS; then IDLE, busy = 0, error and counters cleared.
REQ-020 Pixels beyond NUM_PIXELS SHALL NOT strobe pixel_valid; error latched.
REQ-021 DRAIN: ignore edges; after LATCH_CYCLES consecutive low cycles perform frame end with frame_error = 1.
REQ-022 pixel_valid and frame_done in the same cycle is impossible by construction (latch gap >> 1 cycle); the 24th bit's strobe always precedes frame_done.
REQ-023 Counters SHALL saturate, never wrap; width counter 6 bits, low counter 12 bits, pixel counter 3 bits saturating at NUM_PIXELS.

Reset
REQ-024 Reset SHALL force IDLE, all counters and the shift register to 0, synchronizer flops to 0, all outputs to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no frame_done; decoding restarts at the next rising edge.

Structure
REQ-026 Shared package neopixel_pkg: timing constants (LATCH_CYCLES, T_MIN, T_SPLIT, T_MAX), 24-bit GRB pixel typedef, decoder state enum.
REQ-027 One sub-module, pulse_width_meter: synchronizer, edge detect, saturating width counter; emits rise, fall, width.
REQ-028 Implementation target 150-300 lines.

Verification
REQ-029 Bus model sends 5 pixels G=8'hFF R=8'h00 B=8'hA5 (0-bit 18 high/44 low, 1-bit 35 high/27 low), then 2600 low -> 5 pixel_valid, indices 0..4, correct GRB, frame_done with frame_error = 0.
REQ-030 Drive the NeoPixelStrandController output after loading distinct colors per pixel -> decoded values match loaded values pixel-for-pixel, frame_error = 0.
REQ-031 Frame of 3 pixels + 10 bits, then latch -> 3 strobes, frame_done with frame_error = 1, partial word not strobed.
REQ-032 One high pulse of 60 cycles mid-frame -> DRAIN, no further strobes, frame_done frame_error = 1 after 2500 low cycles.
REQ-033 Widths 7, 8, 26, 27, 50, 51 -> error, 0, 0, 1, 1, error.
REQ-034 Assert reset during pixel 2 -> outputs 0, no frame_done; following clean frame decodes with frame_error = 0.
